mips_multicycle_ctrl: RTL and testbench

//  Control FSM for the multi-cycle MIPS datapath: Moore-decoded mux selects/write enables, ALU decoder, PC enable.

---
 rtl/mips_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with mem_ready wait states, bounded memory timeout and illegal-op flag.
// Optional jump support is built when MIPS_CTRL_JUMP_EN is defined.
module mips_multicycle_ctrl #(
  parameter int TMO_MAX = 16,
  parameter int TMO_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic             bus_err_q, bus_err_d;
  logic             is_sw_q, is_sw_d;
  logic             wait_st, timeout;
  logic             rt_ok;
  logic [2:0]       rt_alu;
  logic             pc_write, branch;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  // Timeout fires on the TMO_MAX-th consecutive wait cycle; a ready memory always wins.
  always_comb begin
    timeout = 1'b0;
    if (TMO_MAX != 0)
      timeout = wait_st && !mem_ready && (wait_q == TMO_W'(TMO_MAX - 1));
  end

  always_comb begin
    rt_ok  = 1'b1;
    rt_alu = 3'b010;
    case (funct)
      6'b100000: rt_alu = 3'b010;
      6'b100010: rt_alu = 3'b110;
      6'b100100: rt_alu = 3'b000;
      6'b100101: rt_alu = 3'b001;
      6'b101010: rt_alu = 3'b111;
      default:   rt_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          6'b000000: state_d = S_RTYPEEX;
          6'b100011: begin state_d = S_MEMADR; is_sw_d = 1'b0; end
          6'b101011: begin state_d = S_MEMADR; is_sw_d = 1'b1; end
          6'b000100: state_d = S_BEQEX;
          6'b001000: state_d = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
          6'b000010: state_d = S_JEX;
`endif
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_RTYPEEX: state_d = rt_ok ? S_RTYPEWB : S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // A FETCH timeout does not change state, so the counter must also clear on timeout itself.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || timeout)
      wait_d = '0;
    else if (wait_st && !mem_ready && (wait_q != '1))
      wait_d = wait_q + 1'b1;
  end

  assign bus_err_d = bus_err_q | timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      is_sw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      is_sw_q   <= is_sw_d;
    end
  end

  // Moore decode; gated by reset so in-flight enables drop as soon as reset asserts.
  always_comb begin
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b010;
    pc_src      = 2'b00;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal_o   = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000: illegal_o = 1'b0;
`ifdef MIPS_CTRL_JUMP_EN
            6'b000010: illegal_o = 1'b0;
`endif
            default: illegal_o = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = !timeout;
        end
        S_RTYPEEX: begin
          alu_src_a   = 1'b1;
          alu_control = rt_alu;
          illegal_o   = !rt_ok;
        end
        S_RTYPEWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BEQEX: begin
          alu_src_a   = 1'b1;
          alu_control = 3'b110;
          pc_src      = 2'b01;
          branch      = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
        S_JEX: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign pc_en       = pc_write | (branch & zero);
  assign bus_err_o   = bus_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class, wait states, timeout and reset.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, WB = 4'd4, MW = 4'd5,
                         RX = 4'd6, RW = 4'd7, BQ = 4'd8, AX = 4'd9, AW = 4'd10, JX = 4'd11;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       pc_en, illegal_o, bus_err_o;
  logic [3:0] dbg_state;
  logic [15:0] ctl_obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TMO_MAX(16), .TMO_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .illegal_o(illegal_o),
    .bus_err_o(bus_err_o), .dbg_state_o(dbg_state)
  );

  assign ctl_obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                    alu_src_b, alu_control, pc_src, pc_en, illegal_o};

  function automatic logic [15:0] ctl(input logic io, mw, irw, rd, m2r, rw, sa,
                                      input logic [1:0] sb, input logic [2:0] ac,
                                      input logic [1:0] ps, input logic pe, ill);
    return {io, mw, irw, rd, m2r, rw, sa, sb, ac, ps, pe, ill};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic at(input string tag, input logic [3:0] st, input logic [15:0] cv);
    #1;
    chk({tag, "/state"}, {12'h000, dbg_state}, {12'h000, st});
    chk({tag, "/ctl"}, ctl_obs, cv);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  logic [15:0] v_zero, v_f1, v_f0, v_dec, v_dec_ill, v_ma, v_mr, v_wb, v_mw;
  logic [15:0] v_rx_slt, v_rx_sub, v_rx_add, v_rx_ill, v_rw, v_beq1, v_beq0, v_ax, v_aw, v_j;

  initial begin
    v_zero    = ctl(0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
    v_f1      = ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
    v_f0      = ctl(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
    v_dec     = ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
    v_dec_ill = ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
    v_ma      = ctl(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
    v_mr      = ctl(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
    v_wb      = ctl(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0);
    v_mw      = ctl(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
    v_rx_slt  = ctl(0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0);
    v_rx_sub  = ctl(0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0);
    v_rx_add  = ctl(0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0);
    v_rx_ill  = ctl(0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,1);
    v_rw      = ctl(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0);
    v_beq1    = ctl(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0);
    v_beq0    = ctl(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0);
    v_ax      = ctl(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
    v_aw      = ctl(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0);
    v_j       = ctl(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0);

    reset = 1'b0; opcode = 6'b100011; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;

    // Reset state: everything quiet even though mem_ready is high.
    nxt();
    at("reset", F, v_zero);
    chk("reset/bus_err", {15'd0, bus_err_o}, 16'd0);
    reset = 1'b1;

    // lw, no wait states: 5 cycles, writeback only in the 5th.
    at("lw/fetch", F, v_f1);  nxt();
    at("lw/decode", D, v_dec); nxt();
    at("lw/memadr", MA, v_ma); nxt();
    at("lw/memrd", MR, v_mr);  nxt();
    at("lw/memwb", WB, v_wb);  nxt();

    // sw with 3 wait cycles: mem_write held 4 cycles.
    opcode = 6'b101011;
    at("sw/fetch", F, v_f1);  nxt();
    at("sw/decode", D, v_dec); nxt();
    at("sw/memadr", MA, v_ma); nxt();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at("sw/wait", MW, v_mw); nxt();
    end
    mem_ready = 1'b1;
    at("sw/ready", MW, v_mw); nxt();
    chk("sw/bus_err", {15'd0, bus_err_o}, 16'd0);

    // beq taken then not taken.
    opcode = 6'b000100; zero = 1'b1;
    at("beq1/fetch", F, v_f1);  nxt();
    at("beq1/decode", D, v_dec); nxt();
    at("beq1/ex", BQ, v_beq1);  nxt();
    zero = 1'b0;
    at("beq0/fetch", F, v_f1);  nxt();
    at("beq0/decode", D, v_dec); nxt();
    at("beq0/ex", BQ, v_beq0);  nxt();

    // R-type slt and sub, then an unknown funct.
    opcode = 6'b000000; funct = 6'b101010;
    at("slt/fetch", F, v_f1);  nxt();
    at("slt/decode", D, v_dec); nxt();
    at("slt/ex", RX, v_rx_slt); nxt();
    at("slt/wb", RW, v_rw);    nxt();
    funct = 6'b100010;
    at("sub/fetch", F, v_f1);  nxt();
    at("sub/decode", D, v_dec); nxt();
    at("sub/ex", RX, v_rx_sub); nxt();
    at("sub/wb", RW, v_rw);    nxt();
    funct = 6'b111111;
    at("rill/fetch", F, v_f1);  nxt();
    at("rill/decode", D, v_dec); nxt();
    at("rill/ex", RX, v_rx_ill); nxt();

    // addi with 3 fetch wait cycles.
    opcode = 6'b001000; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at("addi/fwait", F, v_f0); nxt();
    end
    mem_ready = 1'b1;
    at("addi/fetch", F, v_f1);  nxt();
    at("addi/decode", D, v_dec); nxt();
    at("addi/ex", AX, v_ax);    nxt();
    at("addi/wb", AW, v_aw);    nxt();

    // Unknown opcode.
    opcode = 6'b111111;
    at("opill/fetch", F, v_f1);  nxt();
    at("opill/decode", D, v_dec_ill); nxt();

    // Jump: built or illegal depending on the build.
    opcode = 6'b000010;
    at("j/fetch", F, v_f1); nxt();
`ifdef MIPS_CTRL_JUMP_EN
    at("j/decode", D, v_dec); nxt();
    at("j/ex", JX, v_j);      nxt();
`else
    at("j/decode", D, v_dec_ill); nxt();
`endif

    // lw with 15 wait cycles then ready on the 16th: no timeout.
    opcode = 6'b100011;
    at("lw15/fetch", F, v_f1);  nxt();
    at("lw15/decode", D, v_dec); nxt();
    at("lw15/memadr", MA, v_ma); nxt();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      at("lw15/wait", MR, v_mr); nxt();
    end
    mem_ready = 1'b1;
    at("lw15/ready", MR, v_mr); nxt();
    at("lw15/memwb", WB, v_wb); nxt();
    chk("lw15/bus_err", {15'd0, bus_err_o}, 16'd0);

    // lw timeout: 16 wait cycles in MEMRD abort to FETCH with bus_err set.
    at("lwto/fetch", F, v_f1);  nxt();
    at("lwto/decode", D, v_dec); nxt();
    at("lwto/memadr", MA, v_ma); nxt();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      at("lwto/wait", MR, v_mr); nxt();
      if (i < 15) chk("lwto/bus_err_low", {15'd0, bus_err_o}, 16'd0);
    end
    at("lwto/abort", F, v_f0);
    chk("lwto/bus_err", {15'd0, bus_err_o}, 16'd1);
    mem_ready = 1'b1;
    nxt();

    // sw timeout: mem_write drops in the 16th wait cycle; bus_err stays sticky.
    opcode = 6'b101011;
    at("swto/decode", D, v_dec); nxt();
    at("swto/memadr", MA, v_ma); nxt();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      at("swto/wait", MW, v_mw); nxt();
    end
    at("swto/last", MW, v_mr); nxt();
    at("swto/abort", F, v_f0);
    chk("swto/bus_err", {15'd0, bus_err_o}, 16'd1);
    mem_ready = 1'b1;

    // Reset asserted in RTYPEWB: writes drop at once, FETCH afterwards.
    opcode = 6'b000000; funct = 6'b100000;
    at("rst/fetch", F, v_f1);   nxt();
    at("rst/decode", D, v_dec);  nxt();
    at("rst/ex", RX, v_rx_add);  nxt();
    at("rst/wb", RW, v_rw);
    reset = 1'b0;
    at("rst/async", F, v_zero);
    chk("rst/bus_err", {15'd0, bus_err_o}, 16'd0);
    nxt();
    reset = 1'b1;
    at("rst/release", F, v_f1);
    nxt();
    at("rst/decode2", D, v_dec);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
